// File: rtl/frog_pkg.sv
// Shared types and constants for the Frogger round/score sequencer.
package frog_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    RESPAWN = 3'd2,
    WIN     = 3'd3,
    OVER    = 3'd4
  } state_t;

  localparam int BCD_W = 4;

endpackage

// File: rtl/frog_round_ctrl_sat_counter.sv
// Saturating up/down counter; load returns it to INIT, which is also its reset value.
module sat_counter #(
  parameter int MAX  = 9,
  parameter int INIT = 0,
  parameter int W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = INIT_V;
    end else if (inc && (cnt_q < MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= INIT_V;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/frog_round_ctrl.sv
// Frogger game FSM: turns collision events into score/lives updates, gates frog movement, pulses respawn.
module frog_round_ctrl
  import frog_pkg::*;
#(
  parameter int SCORE_MAX      = 7,
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             home_evt,
  input  logic             hit_evt,
  output logic             frog_en,
  output logic             respawn,
  output logic [BCD_W-1:0] score,
  output logic [BCD_W-1:0] lives,
  output logic             win,
  output logic             game_over
);

  localparam int TW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(RESPAWN_CYCLES - 1);
  localparam logic [BCD_W-1:0] SCORE_WIN  = BCD_W'(SCORE_MAX);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_prev_q, home_prev_q, hit_prev_q;
  logic          frog_en_q, frog_en_d;
  logic          respawn_q, respawn_d;
  logic          win_q, win_d;
  logic          game_over_q, game_over_d;
  logic          score_load, score_inc, lives_load, lives_dec;
  logic          start_rise, home_rise, hit_rise;

  assign start_rise = start & ~start_prev_q;
  assign home_rise  = home_evt & ~home_prev_q;
  assign hit_rise   = hit_evt & ~hit_prev_q;

  // Decisions use the pre-update counter value, so "new value" tests are done one step early.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    respawn_d  = 1'b0;
    score_load = 1'b0;
    score_inc  = 1'b0;
    lives_load = 1'b0;
    lives_dec  = 1'b0;
    case (state_q)
      IDLE, WIN, OVER: begin
        if (start_rise) begin
          state_d    = PLAY;
          score_load = 1'b1;
          lives_load = 1'b1;
          respawn_d  = 1'b1;
        end
      end
      PLAY: begin
        if (hit_rise) begin
          lives_dec = 1'b1;
          timer_d   = TIMER_LOAD;
          state_d   = (lives <= BCD_W'(1)) ? OVER : RESPAWN;
        end else if (home_rise) begin
          score_inc = 1'b1;
          timer_d   = TIMER_LOAD;
          state_d   = (score == SCORE_WIN - BCD_W'(1)) ? WIN : RESPAWN;
        end
      end
      RESPAWN: begin
        if (timer_q == '0) begin
          state_d   = PLAY;
          respawn_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    frog_en_d   = (state_d == PLAY);
    win_d       = (state_d == WIN);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      start_prev_q <= 1'b0;
      home_prev_q  <= 1'b0;
      hit_prev_q   <= 1'b0;
      frog_en_q    <= 1'b0;
      respawn_q    <= 1'b0;
      win_q        <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      start_prev_q <= start;
      home_prev_q  <= home_evt;
      hit_prev_q   <= hit_evt;
      frog_en_q    <= frog_en_d;
      respawn_q    <= respawn_d;
      win_q        <= win_d;
      game_over_q  <= game_over_d;
    end
  end

  sat_counter #(.MAX(SCORE_MAX), .INIT(0), .W(BCD_W)) u_score (
    .clk   (clk),
    .reset (reset),
    .load  (score_load),
    .inc   (score_inc),
    .dec   (1'b0),
    .q     (score)
  );

  sat_counter #(.MAX(LIVES_INIT), .INIT(LIVES_INIT), .W(BCD_W)) u_lives (
    .clk   (clk),
    .reset (reset),
    .load  (lives_load),
    .inc   (1'b0),
    .dec   (lives_dec),
    .q     (lives)
  );

  assign frog_en   = frog_en_q;
  assign respawn   = respawn_q;
  assign win       = win_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Self-checking bench for frog_round_ctrl: vector table plus hand sequences, checked through a scoreboard queue.
module tb_frog_round_ctrl;

  typedef struct packed {
    logic       frog_en;
    logic       respawn;
    logic [3:0] score;
    logic [3:0] lives;
    logic       win;
    logic       game_over;
  } out_t;

  typedef struct {
    string name;
    logic  rst;
    logic  st;
    logic  hm;
    logic  ht;
    out_t  exp;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       home_evt = 1'b0;
  logic       hit_evt = 1'b0;
  logic       frog_en, respawn, win, game_over;
  logic [3:0] score, lives;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  frog_round_ctrl #(.SCORE_MAX(7), .LIVES_INIT(3), .RESPAWN_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .home_evt  (home_evt),
    .hit_evt   (hit_evt),
    .frog_en   (frog_en),
    .respawn   (respawn),
    .score     (score),
    .lives     (lives),
    .win       (win),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time-out, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic out_t mk(input logic fe, input logic rp, input int sc, input int lv,
                              input logic wn, input logic go);
    out_t o;
    o.frog_en   = fe;
    o.respawn   = rp;
    o.score     = 4'(sc);
    o.lives     = 4'(lv);
    o.win       = wn;
    o.game_over = go;
    return o;
  endfunction

  task automatic addVec(input string n, input logic r, input logic s, input logic h,
                        input logic t, input out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.st = s; v.hm = h; v.ht = t; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs away from the sampling edge and record what must follow it.
  task automatic applyStimulus(input string n, input logic r, input logic s, input logic h,
                               input logic t, input out_t e);
    sb_t item;
    @(negedge clk);
    reset    = r;
    start    = s;
    home_evt = h;
    hit_evt  = t;
    item.name = n;
    item.exp  = e;
    sb.push_back(item);
  endtask

  task automatic checkOutput();
    sb_t  item;
    out_t act;
    @(posedge clk);
    #1;
    act = {frog_en, respawn, score, lives, win, game_over};
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, want one queued");
      return;
    end
    item = sb.pop_front();
    total++;
    if (act !== item.exp) begin
      bad++;
      $display("[TB] FAIL %s: got fe=%0b rp=%0b sc=%0d lv=%0d win=%0b go=%0b, want fe=%0b rp=%0b sc=%0d lv=%0d win=%0b go=%0b",
               item.name, act.frog_en, act.respawn, act.score, act.lives, act.win, act.game_over,
               item.exp.frog_en, item.exp.respawn, item.exp.score, item.exp.lives,
               item.exp.win, item.exp.game_over);
    end
  endtask

  task automatic step(input string n, input logic r, input logic s, input logic h,
                      input logic t, input out_t e);
    applyStimulus(n, r, s, h, t, e);
    checkOutput();
  endtask

  initial begin
    // Reset, start, held home, simultaneous home+hit, lives down to 0, restart from OVER.
    addVec("reset",        1, 0, 0, 0, mk(0, 0, 0, 3, 0, 0));
    addVec("start",        0, 1, 0, 0, mk(1, 1, 0, 3, 0, 0));
    addVec("play_quiet",   0, 0, 0, 0, mk(1, 0, 0, 3, 0, 0));
    addVec("home_rise",    0, 0, 1, 0, mk(0, 0, 1, 3, 0, 0));
    addVec("home_hold1",   0, 0, 1, 0, mk(0, 0, 1, 3, 0, 0));
    addVec("home_hold2",   0, 0, 1, 0, mk(0, 0, 1, 3, 0, 0));
    addVec("home_hold3",   0, 0, 1, 0, mk(0, 0, 1, 3, 0, 0));
    addVec("home_resp",    0, 0, 1, 0, mk(1, 1, 1, 3, 0, 0));
    addVec("home_release", 0, 0, 0, 0, mk(1, 0, 1, 3, 0, 0));
    addVec("hit_and_home", 0, 0, 1, 1, mk(0, 0, 1, 2, 0, 0));
    addVec("resp_a1",      0, 0, 0, 0, mk(0, 0, 1, 2, 0, 0));
    addVec("resp_a2",      0, 0, 0, 0, mk(0, 0, 1, 2, 0, 0));
    addVec("resp_a3",      0, 0, 0, 0, mk(0, 0, 1, 2, 0, 0));
    addVec("resp_a_done",  0, 0, 0, 0, mk(1, 1, 1, 2, 0, 0));
    addVec("hit2",         0, 0, 0, 1, mk(0, 0, 1, 1, 0, 0));
    addVec("hit2_hold1",   0, 0, 0, 1, mk(0, 0, 1, 1, 0, 0));
    addVec("hit2_hold2",   0, 0, 0, 1, mk(0, 0, 1, 1, 0, 0));
    addVec("hit2_hold3",   0, 0, 0, 1, mk(0, 0, 1, 1, 0, 0));
    addVec("resp_b_done",  0, 0, 0, 0, mk(1, 1, 1, 1, 0, 0));
    addVec("hit3_over",    0, 0, 0, 1, mk(0, 0, 1, 0, 0, 1));
    addVec("over_quiet",   0, 0, 0, 0, mk(0, 0, 1, 0, 0, 1));
    addVec("over_hit",     0, 0, 0, 1, mk(0, 0, 1, 0, 0, 1));
    addVec("over_start",   0, 1, 0, 0, mk(1, 1, 0, 3, 0, 0));
    addVec("start_held",   0, 1, 0, 0, mk(1, 0, 0, 3, 0, 0));
    addVec("start_low",    0, 0, 0, 0, mk(1, 0, 0, 3, 0, 0));
    addVec("start_in_play",0, 1, 0, 0, mk(1, 0, 0, 3, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].st, vecs[i].hm, vecs[i].ht, vecs[i].exp);
    end

    // Seven home rises, each followed by a full respawn window, until WIN.
    for (int k = 1; k <= 7; k++) begin
      if (k < 7) begin
        step("win_seq_home", 0, 0, 1, 0, mk(0, 0, k, 3, 0, 0));
        for (int c = 0; c < 3; c++) step("win_seq_wait", 0, 0, 0, 0, mk(0, 0, k, 3, 0, 0));
        step("win_seq_resp", 0, 0, 0, 0, mk(1, 1, k, 3, 0, 0));
      end else begin
        step("win_reached", 0, 0, 1, 0, mk(0, 0, 7, 3, 1, 0));
      end
    end
    step("win_hold",       0, 0, 0, 0, mk(0, 0, 7, 3, 1, 0));
    step("win_home_rise",  0, 0, 1, 0, mk(0, 0, 7, 3, 1, 0));
    step("win_hit_rise",   0, 0, 0, 1, mk(0, 0, 7, 3, 1, 0));
    for (int c = 0; c < 4; c++) step("win_no_resp", 0, 0, 0, 0, mk(0, 0, 7, 3, 1, 0));

    // Restart from WIN, then reset in the middle of a respawn countdown.
    step("win_start",      0, 1, 0, 0, mk(1, 1, 0, 3, 0, 0));
    step("restart_play",   0, 0, 0, 0, mk(1, 0, 0, 3, 0, 0));
    step("mid_hit",        0, 0, 0, 1, mk(0, 0, 0, 2, 0, 0));
    step("mid_resp1",      0, 0, 0, 0, mk(0, 0, 0, 2, 0, 0));
    step("mid_resp2",      0, 0, 0, 0, mk(0, 0, 0, 2, 0, 0));
    step("mid_reset",      1, 1, 0, 0, mk(0, 0, 0, 3, 0, 0));
    step("reset_hold",     1, 1, 0, 0, mk(0, 0, 0, 3, 0, 0));
    step("post_reset",     0, 1, 0, 0, mk(1, 1, 0, 3, 0, 0));
    step("post_reset_hold",0, 1, 0, 0, mk(1, 0, 0, 3, 0, 0));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
